// File: rtl/tlc_pkg.sv
// Shared definitions for the multi-phase traffic-light controller.
// Contents:
//   tlc_state_t   : 2-bit FSM state (GREEN / YELLOW / ALLRED; 2'b11 is illegal)
//   tlc_max3      : helper returning the largest of three integers
//   tlc_params_ok : elaboration-time legality check for the top-level parameters
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } tlc_state_t;

  function automatic int tlc_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // The timer has to count up to the longest interval it times, and timer+1
  // must not wrap, so that longest interval has to fit in CNT_W bits.
  function automatic bit tlc_params_ok(input int n_phases, input int cnt_w,
                                       input int green_min, input int green_max,
                                       input int yellow_t, input int allred_t);
    bit ok;
    ok = 1'b1;
    if (n_phases < 2 || n_phases > 8)   ok = 1'b0;
    if (cnt_w < 1 || cnt_w > 30)        ok = 1'b0;
    if (green_min < 1)                  ok = 1'b0;
    if (green_max < green_min)          ok = 1'b0;
    if (yellow_t < 1)                   ok = 1'b0;
    if (allred_t < 0)                   ok = 1'b0;
    if (ok && tlc_max3(green_max, yellow_t, allred_t) >= (1 << cnt_w)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Round-robin successor search for the traffic-light controller.
// Ports:
//   pend      in  N_PHASES  latched per-phase requests
//   cur       in  PW        phase currently holding right-of-way
//   nxt_idx   out PW        first pending phase after cur (cur+1, cur+2, ... wrapping)
//   any_other out 1         some phase other than cur is pending
// Purely combinational. When any_other is 0, nxt_idx is just cur and is unused.
module tlc_rr_arbiter #(
  parameter int N_PHASES = 4,
  parameter int PW       = 2
) (
  input  logic [N_PHASES-1:0] pend,
  input  logic [PW-1:0]       cur,
  output logic [PW-1:0]       nxt_idx,
  output logic                any_other
);

  logic [N_PHASES-1:0] cur_oh;
  int unsigned         idx;

  // Walk the offsets from farthest to nearest so the nearest pending phase
  // after cur is the last one written and therefore wins.
  always_comb begin
    cur_oh    = N_PHASES'(1) << cur;
    any_other = |(pend & ~cur_oh);
    nxt_idx   = cur;
    idx       = 0;
    for (int k = N_PHASES - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % N_PHASES;
      if (|(pend & (N_PHASES'(1) << idx))) nxt_idx = PW'(idx);
    end
  end

endmodule

// File: rtl/tlc_multi_phase.sv
// N-approach traffic-light controller serving phases round-robin from latched
// vehicle requests, with min/max green, fixed yellow and optional all-red.
// Ports:
//   clk    in  1         rising-edge clock
//   rst_n  in  1         asynchronous active-low reset
//   ena    in  1         timing tick; FSM and timer only advance when high
//   req    in  N_PHASES  synchronised level-sensitive vehicle sensors
//   lamp_g out N_PHASES  green lamps
//   lamp_y out N_PHASES  yellow lamps
//   lamp_r out N_PHASES  red lamps
//   phase  out PW        phase holding right-of-way
//   st     out 2         FSM state (00 GREEN, 01 YELLOW, 10 ALLRED)
module tlc_multi_phase
  import tlc_pkg::*;
#(
  parameter int N_PHASES  = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int PW        = $clog2(N_PHASES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [N_PHASES-1:0] req,
  output logic [N_PHASES-1:0] lamp_g,
  output logic [N_PHASES-1:0] lamp_y,
  output logic [N_PHASES-1:0] lamp_r,
  output logic [PW-1:0]       phase,
  output logic [1:0]          st
);

  if (!tlc_params_ok(N_PHASES, CNT_W, GREEN_MIN, GREEN_MAX, YELLOW_T, ALLRED_T)) begin : g_bad_params
    $error("tlc_multi_phase: illegal parameter combination");
  end

  // The saturation point covers yellow/all-red as well so that oversized
  // yellow or all-red times still terminate; with sane values it is GREEN_MAX-1.
  localparam int             TMR_SAT = tlc_max3(GREEN_MAX, YELLOW_T, ALLRED_T) - 1;
  localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(TMR_SAT);
  localparam logic [CNT_W-1:0] GMIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMAX_C = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AR_C   = CNT_W'(ALLRED_T);

  tlc_state_t          state, state_next;
  logic [PW-1:0]       cur, cur_next;
  logic [PW-1:0]       nxt, nxt_next;
  logic [CNT_W-1:0]    timer, timer_next, timer_inc;
  logic [N_PHASES-1:0] pend, pend_next;
  logic [N_PHASES-1:0] cur_oh, nxt_oh;
  logic [PW-1:0]       arb_idx;
  logic                any_other;
  logic                req_cur;
  logic                enter_green;

  tlc_rr_arbiter #(
    .N_PHASES (N_PHASES),
    .PW       (PW)
  ) u_arb (
    .pend      (pend),
    .cur       (cur),
    .nxt_idx   (arb_idx),
    .any_other (any_other)
  );

  assign cur_oh    = N_PHASES'(1) << cur;
  assign nxt_oh    = N_PHASES'(1) << nxt;
  assign req_cur   = |(req & cur_oh);
  assign timer_inc = timer + CNT_W'(1);

  // Next-state logic. State changes only on ena ticks, except that the
  // illegal encoding recovers to GREEN immediately.
  always_comb begin
    state_next  = state;
    cur_next    = cur;
    nxt_next    = nxt;
    timer_next  = timer;
    enter_green = 1'b0;

    case (state)
      ST_GREEN: begin
        if (ena && any_other &&
            ((timer_inc >= GMIN_C && !req_cur) || timer_inc >= GMAX_C)) begin
          state_next = ST_YELLOW;
          nxt_next   = arb_idx;
        end
      end
      ST_YELLOW: begin
        if (ena && timer_inc == YEL_C) begin
          if (ALLRED_T > 0) begin
            state_next = ST_ALLRED;
          end else begin
            state_next  = ST_GREEN;
            cur_next    = nxt;
            enter_green = 1'b1;
          end
        end
      end
      ST_ALLRED: begin
        if (ena && timer_inc == AR_C) begin
          state_next  = ST_GREEN;
          cur_next    = nxt;
          enter_green = 1'b1;
        end
      end
      default: begin
        state_next = ST_GREEN;
      end
    endcase

    if (state_next != state) begin
      timer_next = '0;
    end else if (ena && timer != SAT_C) begin
      timer_next = timer_inc;
    end
  end

  // Request latch runs every clock regardless of ena. The phase being served
  // in GREEN does not latch its own request, and the phase about to go green
  // has its request consumed on entry, taking precedence over a new req.
  always_comb begin
    pend_next = pend | (req & ((state == ST_GREEN) ? ~cur_oh : {N_PHASES{1'b1}}));
    if (enter_green) pend_next = pend_next & ~nxt_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GREEN;
      cur   <= '0;
      nxt   <= '0;
      timer <= '0;
      pend  <= '0;
    end else begin
      state <= state_next;
      cur   <= cur_next;
      nxt   <= nxt_next;
      timer <= timer_next;
      pend  <= pend_next;
    end
  end

  // Lamp decode straight from the registers; non-current phases stay red.
  always_comb begin
    lamp_g = '0;
    lamp_y = '0;
    lamp_r = '1;
    case (state)
      ST_GREEN: begin
        lamp_g = cur_oh;
        lamp_r = ~cur_oh;
      end
      ST_YELLOW: begin
        lamp_y = cur_oh;
        lamp_r = ~cur_oh;
      end
      default: begin
        lamp_r = '1;
      end
    endcase
  end

  assign phase = cur;
  assign st    = state;

endmodule

// File: tb/tb_tlc_multi_phase.sv
// Self-checking bench for tlc_multi_phase with default parameters.
// A behavioural model is stepped whenever inputs are driven; its predicted
// post-edge outputs are queued and compared against the DUT after the edge.
module tb_tlc_multi_phase;

  localparam int N    = 4;
  localparam int PW   = 2;
  localparam int CW   = 8;
  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 2;
  localparam int AT   = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lamp_g, lamp_y, lamp_r;
  logic [PW-1:0] phase;
  logic [1:0]    st;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [1:0]   st;
    logic [PW-1:0] phase;
    logic [N-1:0] g;
    logic [N-1:0] y;
    logic [N-1:0] r;
    logic [N-1:0] pend;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state; m_cnt counts completed ticks in the current state
  // without saturation.
  int           m_state;
  int           m_cur;
  int           m_nxt;
  int           m_cnt;
  logic [N-1:0] m_pend;

  tlc_multi_phase #(
    .N_PHASES  (N),
    .CNT_W     (CW),
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .req    (req),
    .lamp_g (lamp_g),
    .lamp_y (lamp_y),
    .lamp_r (lamp_r),
    .phase  (phase),
    .st     (st)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cur   = 0;
    m_nxt   = 0;
    m_cnt   = 0;
    m_pend  = '0;
    exp_q.delete();
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    logic [N-1:0] oh;
    oh     = '0;
    oh[m_cur] = 1'b1;
    e.st   = 2'(m_state);
    e.phase = PW'(m_cur);
    e.g    = (m_state == 0) ? oh : '0;
    e.y    = (m_state == 1) ? oh : '0;
    e.r    = (m_state == 2) ? '1 : ~oh;
    e.pend = m_pend;
    return e;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic e);
    logic [N-1:0] oh, pend_n;
    int ticks, pick, idx;
    bit go_green;
    oh = '0;
    oh[m_cur] = 1'b1;
    pend_n = m_pend | (r & ((m_state == 0) ? ~oh : '1));
    go_green = 1'b0;
    if (e) begin
      ticks = m_cnt + 1;
      if (m_state == 0) begin
        if ((m_pend & ~oh) != '0 &&
            ((ticks >= GMIN && !r[m_cur]) || ticks >= GMAX)) begin
          pick = -1;
          for (int k = 1; k < N; k++) begin
            idx = (m_cur + k) % N;
            if (pick < 0 && m_pend[idx]) pick = idx;
          end
          m_nxt   = pick;
          m_state = 1;
          m_cnt   = 0;
        end else begin
          m_cnt = ticks;
        end
      end else if (m_state == 1) begin
        if (ticks == YT) begin
          if (AT > 0) begin
            m_state = 2;
            m_cnt   = 0;
          end else begin
            go_green = 1'b1;
          end
        end else begin
          m_cnt = ticks;
        end
      end else begin
        if (ticks == AT) go_green = 1'b1;
        else m_cnt = ticks;
      end
    end
    if (go_green) begin
      m_state = 0;
      m_cur   = m_nxt;
      m_cnt   = 0;
      pend_n[m_nxt] = 1'b0;
    end
    m_pend = pend_n;
  endtask

  // Drive one clock of stimulus, predict, then compare after the edge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic e);
    exp_t x;
    req = r;
    ena = e;
    model_step(r, e);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    checkOutput("st_phase", {22'd0, st, 6'd0, phase}, {22'd0, x.st, 6'd0, x.phase});
    checkOutput("lamps", {20'd0, lamp_g, lamp_y, lamp_r}, {20'd0, x.g, x.y, x.r});
    checkOutput("pend", {28'd0, dut.pend}, {28'd0, x.pend});
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    req   = '0;
    ena   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_st", {30'd0, st}, 32'd0);
    checkOutput("rst_phase", {30'd0, phase}, 32'd0);
    checkOutput("rst_lamps", {20'd0, lamp_g, lamp_y, lamp_r}, {20'd0, 4'b0001, 4'b0000, 4'b1110});
  endtask

  initial begin
    int g_cnt, y_cnt, found, budget;
    int order[$];
    logic [1:0] prev_st;
    logic [N-1:0] r;
    logic [2:0] pat;

    // Scenario 1: idle for 50 cycles, phase 0 rests green.
    applyReset();
    for (int i = 0; i < 50; i++) applyStimulus('0, 1'b1);
    checkOutput("s1_lamp_g", {28'd0, lamp_g}, 32'h1);
    checkOutput("s1_lamp_r", {28'd0, lamp_r}, 32'hE);

    // Scenario 2: single req[2] pulse at cycle 5.
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus('0, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus('0, 1'b1);
    checkOutput("s2_phase", {30'd0, phase}, 32'd2);
    checkOutput("s2_lamp_g", {28'd0, lamp_g}, 32'h4);
    checkOutput("s2_pend2", {31'd0, dut.pend[2]}, 32'd0);

    // Scenario 3: req[0] held, req[1] pulsed; green runs to GREEN_MAX.
    // The interval between reset release and the first edge is green too.
    applyReset();
    g_cnt = (lamp_g == 4'b0001) ? 1 : 0;
    applyStimulus(4'b0011, 1'b1);
    if (lamp_g[0]) g_cnt++;
    budget = 0;
    while (lamp_g[0] && budget < 40) begin
      applyStimulus(4'b0001, 1'b1);
      if (lamp_g[0]) g_cnt++;
      budget++;
    end
    checkOutput("s3_green_len", g_cnt, GMAX);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 1'b1);
    checkOutput("s3_phase1", {30'd0, phase}, 32'd1);

    // Scenario 4: from phase 3 green, pend {0,1,2} is served 0,1,2.
    applyReset();
    applyStimulus(4'b1000, 1'b1);
    budget = 0;
    while (!(m_state == 0 && m_cur == 3) && budget < 40) begin
      applyStimulus('0, 1'b1);
      budget++;
    end
    checkOutput("s4_reach_p3", {30'd0, phase}, 32'd3);
    applyStimulus(4'b0111, 1'b1);
    prev_st = st;
    budget = 0;
    while (order.size() < 3 && budget < 200) begin
      applyStimulus('0, 1'b1);
      if (st == 2'b00 && prev_st != 2'b00) order.push_back(int'(phase));
      prev_st = st;
      budget++;
    end
    checkOutput("s4_count", order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < order.size()) checkOutput("s4_order", order[i], i);
    end

    // Scenario 5: ena 1-in-3 during yellow stretches it to 6 clocks;
    // req[1] raised while ena=0 still gets served.
    applyReset();
    applyStimulus(4'b0100, 1'b1);
    budget = 0;
    while (m_state != 1 && budget < 40) begin
      applyStimulus('0, 1'b1);
      budget++;
    end
    y_cnt = (st == 2'b01) ? 1 : 0;
    pat = 3'b100;
    for (int i = 0; i < 6; i++) begin
      r = (i == 0) ? 4'b0010 : 4'b0000;
      applyStimulus(r, pat[i % 3]);
      if (st == 2'b01) y_cnt++;
    end
    checkOutput("s5_yellow_len", y_cnt, 3 * YT);
    found = 0;
    budget = 0;
    while (!found && budget < 80) begin
      applyStimulus('0, 1'b1);
      if (st == 2'b00 && phase == 2'd1) found = 1;
      budget++;
    end
    checkOutput("s5_req1_served", found, 1);

    // Scenario 6: asynchronous reset in ALLRED.
    applyReset();
    applyStimulus(4'b1010, 1'b1);
    budget = 0;
    while (m_state != 2 && budget < 40) begin
      applyStimulus(4'b1000, 1'b1);
      budget++;
    end
    checkOutput("s6_in_allred", {30'd0, st}, 32'd2);
    rst_n = 1'b0;
    #2;
    checkOutput("s6_rst_st", {30'd0, st}, 32'd0);
    checkOutput("s6_rst_phase", {30'd0, phase}, 32'd0);
    checkOutput("s6_rst_lamps", {20'd0, lamp_g, lamp_y, lamp_r}, {20'd0, 4'b0001, 4'b0000, 4'b1110});
    checkOutput("s6_rst_pend", {28'd0, dut.pend}, 32'd0);
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tlc_multi_phase.md
# tlc_multi_phase

Parametrised N-approach traffic-light controller: the successor to the two-road highway/farm controller. It serves up to 8 signal phases round-robin from latched vehicle requests. Each green has a minimum time, a demand-extended maximum time, a fixed yellow, and an optional all-red clearance. It sits behind the sensor-input synchroniser, and its lamp outputs drive the pin mux directly.

## Interface
- N_PHASES, 4: number of phases/approaches, legal range 2..8
- CNT_W, 8: timer width; must hold GREEN_MAX
- GREEN_MIN, 4: minimum green, in ticks, ≥1
- GREEN_MAX, 10: maximum green under own-phase demand, in ticks, ≥GREEN_MIN
- YELLOW_T, 2: yellow duration, in ticks, ≥1
- ALLRED_T, 1: all-red clearance, in ticks; 0 skips the all-red state
- PW, $clog2(N_PHASES): phase index width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  timing tick enable; the FSM and timer advance only on cycles with ena=1
- req  in  N_PHASES  per-phase vehicle sensor, already synchronised, level-sensitive
- lamp_g  out  N_PHASES  green lamp per phase
- lamp_y  out  N_PHASES  yellow lamp per phase
- lamp_r  out  N_PHASES  red lamp per phase
- phase  out  PW  index of the phase currently holding right-of-way
- st  out  2  FSM state: 00 GREEN, 01 YELLOW, 10 ALLRED

## Operation
- **Registers:** state, cur (PW), nxt (PW), timer (CNT_W), pend (N_PHASES).
- **Reset values:** state=GREEN, cur=0, nxt=0, timer=0, pend=0. Lamps at reset: phase 0 green, all other phases red.
- **Request latch:** every clk, independent of ena, pend[i] |= req[i].
  - Exception: req[cur] is not latched while state=GREEN, because that phase is already being served.
  - pend[nxt] is cleared on the cycle that enters GREEN for nxt. The clear wins over a simultaneous req[nxt].
- **Timer:** zeroed on every state change. Otherwise timer increments on each ena tick, saturating at GREEN_MAX-1.
- **other:** |(pend & ~onehot(cur)).
- **GREEN → YELLOW** on an ena tick when other=1 and either:
  - (timer+1 ≥ GREEN_MIN and req[cur]=0), or
  - timer+1 ≥ GREEN_MAX.
- **Resting:** with other=0, GREEN holds indefinitely. There is no forced rotation.
- **nxt selection:** captured at GREEN→YELLOW. It is the first pending index searched in the order cur+1, cur+2, … modulo N_PHASES.
- **YELLOW exit:** leaves when timer+1 == YELLOW_T. Goes to ALLRED if ALLRED_T>0; otherwise goes to GREEN with cur←nxt.
- **ALLRED exit:** leaves when timer+1 == ALLRED_T, going to GREEN with cur←nxt.
- **Lamp decode** (combinational from registered state/cur):
  - GREEN: lamp_g[cur]=1.
  - YELLOW: lamp_y[cur]=1.
  - ALLRED: every phase red.
  - Every non-cur phase is always red.
- **Invariants:** exactly one lamp on per phase; at most one phase non-red.
- **ena=0:** state, timer and cur are frozen; pend keeps latching.
- **Illegal st encoding (11):** recovers to GREEN, timer=0.
- **Reset mid-operation:** an immediate return to the reset values, even from YELLOW or ALLRED.

## Timing
- With ena held at 1, minimum green = GREEN_MIN cycles, yellow = YELLOW_T cycles, all-red = ALLRED_T cycles.
- Lamps, phase and st change in the same cycle as the state register (no output register stage).
- Request to lamp response: a req pulse of ≥1 clk is latched at the next edge.
  - Earliest yellow on the current phase is the tick completing GREEN_MIN.
  - The requested phase goes green YELLOW_T+ALLRED_T ticks later.
- A request arriving for phase nxt during YELLOW or ALLRED is absorbed by the coming green (cleared on entry).

## Structure
- **Package tlc_pkg:** state encodings ST_GREEN/ST_YELLOW/ST_ALLRED, the 2-bit state typedef, and the parameter legality check function.
- **Sub-module tlc_rr_arbiter** (combinational, N_PHASES/PW parameters): inputs pend and cur; outputs nxt_idx and any_other.
- **Top:** the FSM, timer, pend register and lamp decode.

## Test plan
All scenarios use default parameters with ena=1 unless stated.

1. Reset, no req for 50 cycles → phase=0, lamp_g=4'b0001, lamp_r=4'b1110 throughout.
2. Pulse req[2] at cycle 5 → yellow on phase 0 after 4 green ticks, 2 yellow, 1 all-red, then lamp_g=4'b0100, phase=2, pend[2]=0.
3. Hold req[0] high, pulse req[1] → phase 0 green lasts exactly 10 ticks (GREEN_MAX), then the sequence yellow(2) → all-red(1) → phase 1 green.
4. While phase 3 is green, pend={0,1,2} → service order 0, 1, 2 (wrap-around round-robin).
5. Toggle ena 1-in-3 during yellow → yellow lasts 6 clk; a req[1] asserted while ena=0 is still latched and served.
6. Assert rst_n=0 during ALLRED → same-cycle (asynchronous) return to phase 0 green, pend=0, st=00.
